k_and_s_control_unit: RTL and testbench
=======================================

// Module: k_and_s_control_unit
// PURPOSE
//  Multi-cycle control FSM of the K&S processor. Consumes the decoded_instruction_type opcode
//  (k_and_s_pkg) from the decode stage and the registered ALU flags. Sequences fetch/decode/execute,
//  the RAM request/ready handshake, datapath enables and halt/bus-error. Sits between decode and datapath.
// PARAMETERS
//  MEM_TIMEOUT  16  cycles to wait for mem_ready before bus error; 0 = wait forever
//  CNT_W        32  width of retired-instruction counter
// PORTS
//  clk                 in   1      single clock, rising edge
//  rst                 in   1      reset: synchronous, active-high
//  decoded_instruction in   5      decoded_instruction_type; valid in DECODE state
//  zero_op             in   1      flags register: zero
//  neg_op              in   1      flags register: negative
//  overflow_op         in   1      flags register: signed overflow
//  mem_ready           in   1      RAM completed current request (single-cycle pulse)
//  mem_req             out  1      RAM request, held until mem_ready
//  ram_write_enable    out  1      RAM write qualifier, valid with mem_req
//  addr_sel            out  1      0 = PC drives RAM address, 1 = IR operand address
//  ir_enable           out  1      load IR from RAM data
//  pc_enable           out  1      update PC
//  branch              out  1      with pc_enable: PC <= branch target, else PC <= PC+1
//  write_reg_enable    out  1      write register file
//  c_sel               out  2      RF write source: 0 ALU, 1 RAM data, 2 operand register (MOVE)
//  operation           out  2      ALU op: 00 ADD, 01 SUB, 10 AND, 11 OR
//  flags_reg_enable    out  1      latch ALU flags
//  illegal_instr       out  1      1-cycle pulse on unknown opcode
//  halt                out  1      sticky; processor stopped
//  bus_error           out  1      sticky; memory timeout
//  instr_count         out  CNT_W  retired instructions, wraps to 0
// BEHAVIOUR
//  Reset: state=FETCH, every output 0, instr_count=0, timeout counter=0; reset wins in any state.
//  All outputs other than counters are combinational from state (+ inputs where noted); 0 unless stated.
//  FETCH: mem_req=1, addr_sel=0. On mem_ready: ir_enable=1, pc_enable=1 (branch=0) same cycle -> DECODE.
//  DECODE (1 cycle): I_NOP -> FETCH, retire; I_LOAD/I_STORE -> MEM; I_HALT -> HALTED, retire;
//   ADD/SUB/AND/OR/MOVE/branches -> EXEC; any other code -> FETCH, illegal_instr=1, not retired.
//  MEM: mem_req=1, addr_sel=1, ram_write_enable=(STORE). On mem_ready: LOAD asserts
//   write_reg_enable=1, c_sel=1 in that cycle; -> FETCH, retire.
//  EXEC (1 cycle), -> FETCH, retire:
//   ADD/SUB/AND/OR: write_reg_enable=1, c_sel=0, operation per op, flags_reg_enable=1.
//   MOVE: write_reg_enable=1, c_sel=2, flags_reg_enable=0.
//   Branch: pc_enable=branch=taken. BRANCH always; BZERO zero_op; BNZERO !zero_op; BNEG neg_op;
//   BNNEG !neg_op; BOV overflow_op; BNOV !overflow_op. Not taken: no PC update (PC already +1).
//  HALTED: halt=1; absorbing until rst; no mem_req, no enables.
//  Latency: NOP/HALT/illegal 2 cycles + fetch wait; ALU/MOVE/branch 3 + fetch wait; LOAD/STORE 3 + both waits.
//  Timeout: counter clears on entering FETCH/MEM and on mem_ready; increments each cycle mem_req=1 without
//   mem_ready. If MEM_TIMEOUT>0 and count reaches MEM_TIMEOUT-1 with mem_ready=0 -> HALTED, bus_error=1
//   (sticky), halt=1. mem_ready in that same cycle wins (normal completion).
//  mem_req never drops before mem_ready unless reset/timeout; mem_ready outside FETCH/MEM ignored.
//  instr_count increments by 1 in the retire cycle; all-ones + 1 wraps to 0.
// TESTING
//  Reset mid-MEM (mem_req=1) -> next cycle state FETCH, all outputs 0, instr_count=0.
//  ADD with mem_ready after 3 wait cycles -> DECODE 4 cycles after request, EXEC asserts write_reg_enable,
//   c_sel=0, operation=00, flags_reg_enable=1; instr_count 0->1.
//  BZERO with zero_op=1 -> EXEC pc_enable=1, branch=1; with zero_op=0 -> pc_enable=0; same for all 7 conds.
//  LOAD then STORE -> MEM addr_sel=1; LOAD write_reg_enable+c_sel=1 only on mem_ready cycle; STORE ram_write_enable=1.
//  MEM_TIMEOUT=16, mem_ready never -> 16th request cycle enters HALTED, bus_error=1, halt=1, mem_req=0 after.
//  Opcode 5'b10101 -> illegal_instr 1 cycle, back to FETCH, instr_count unchanged; I_HALT -> halt sticky.

Source files
------------

// File: rtl/k_and_s_control_unit.sv
// K&S processor control unit: multi-cycle fetch/decode/execute sequencer with
// RAM handshake, memory timeout (bus error), halt and retired-instruction counter.

package k_and_s_pkg;
    typedef enum logic [4:0] {
        I_NOP    = 5'd0,
        I_LOAD   = 5'd1,
        I_STORE  = 5'd2,
        I_MOVE   = 5'd3,
        I_ADD    = 5'd4,
        I_SUB    = 5'd5,
        I_AND    = 5'd6,
        I_OR     = 5'd7,
        I_BRANCH = 5'd8,
        I_BZERO  = 5'd9,
        I_BNZERO = 5'd10,
        I_BNEG   = 5'd11,
        I_BNNEG  = 5'd12,
        I_BOV    = 5'd13,
        I_BNOV   = 5'd14,
        I_HALT   = 5'd31
    } decoded_instruction_type;
endpackage

module k_and_s_control_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       decoded_instruction,
    input  logic             zero_op,
    input  logic             neg_op,
    input  logic             overflow_op,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             ram_write_enable,
    output logic             addr_sel,
    output logic             ir_enable,
    output logic             pc_enable,
    output logic             branch,
    output logic             write_reg_enable,
    output logic [1:0]       c_sel,
    output logic [1:0]       operation,
    output logic             flags_reg_enable,
    output logic             illegal_instr,
    output logic             halt,
    output logic             bus_error,
    output logic [CNT_W-1:0] instr_count
);
    import k_and_s_pkg::*;

    localparam int TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_MEM,
        S_EXEC,
        S_HALTED
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [4:0]  op_q;
    logic [TW-1:0] tmo_cnt;
    logic        bus_error_q;
    logic        retire;
    logic        waiting;
    logic        timeout_hit;
    logic        taken;

    assign waiting     = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;
    assign timeout_hit = (MEM_TIMEOUT > 0) && waiting && (tmo_cnt == TMO_LAST);

    always_comb begin
        taken = 1'b0;
        case (op_q)
            I_BRANCH: taken = 1'b1;
            I_BZERO:  taken = zero_op;
            I_BNZERO: taken = !zero_op;
            I_BNEG:   taken = neg_op;
            I_BNNEG:  taken = !neg_op;
            I_BOV:    taken = overflow_op;
            I_BNOV:   taken = !overflow_op;
            default:  taken = 1'b0;
        endcase
    end

    // Next-state and retire decision; DECODE steers on the live opcode, later states on op_q.
    always_comb begin
        next_state = state;
        retire     = 1'b0;
        case (state)
            S_FETCH: begin
                if (mem_ready)        next_state = S_DECODE;
                else if (timeout_hit) next_state = S_HALTED;
            end
            S_DECODE: begin
                case (decoded_instruction)
                    I_NOP: begin
                        next_state = S_FETCH;
                        retire     = 1'b1;
                    end
                    I_HALT: begin
                        next_state = S_HALTED;
                        retire     = 1'b1;
                    end
                    I_LOAD, I_STORE: next_state = S_MEM;
                    I_MOVE, I_ADD, I_SUB, I_AND, I_OR,
                    I_BRANCH, I_BZERO, I_BNZERO, I_BNEG,
                    I_BNNEG, I_BOV, I_BNOV: next_state = S_EXEC;
                    default: next_state = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    next_state = S_FETCH;
                    retire     = 1'b1;
                end else if (timeout_hit) begin
                    next_state = S_HALTED;
                end
            end
            S_EXEC: begin
                next_state = S_FETCH;
                retire     = 1'b1;
            end
            default: next_state = S_HALTED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FETCH;
            op_q        <= I_NOP;
            tmo_cnt     <= '0;
            bus_error_q <= 1'b0;
            instr_count <= '0;
        end else begin
            state <= next_state;
            if (state == S_DECODE) op_q <= decoded_instruction;
            tmo_cnt <= waiting ? tmo_cnt + TW'(1) : '0;
            if (timeout_hit) bus_error_q <= 1'b1;
            if (retire) instr_count <= instr_count + CNT_W'(1);
        end
    end

    // Outputs are held low while rst is asserted so the reset cycle is fully quiet.
    always_comb begin
        mem_req          = 1'b0;
        ram_write_enable = 1'b0;
        addr_sel         = 1'b0;
        ir_enable        = 1'b0;
        pc_enable        = 1'b0;
        branch           = 1'b0;
        write_reg_enable = 1'b0;
        c_sel            = 2'd0;
        operation        = 2'b00;
        flags_reg_enable = 1'b0;
        illegal_instr    = 1'b0;
        halt             = 1'b0;
        bus_error        = 1'b0;
        if (!rst) begin
            bus_error = bus_error_q;
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_enable = 1'b1;
                        pc_enable = 1'b1;
                    end
                end
                S_DECODE: begin
                    if (next_state == S_FETCH && decoded_instruction != I_NOP)
                        illegal_instr = 1'b1;
                end
                S_MEM: begin
                    mem_req          = 1'b1;
                    addr_sel         = 1'b1;
                    ram_write_enable = (op_q == I_STORE);
                    if (mem_ready && op_q == I_LOAD) begin
                        write_reg_enable = 1'b1;
                        c_sel            = 2'd1;
                    end
                end
                S_EXEC: begin
                    case (op_q)
                        I_ADD, I_SUB, I_AND, I_OR: begin
                            write_reg_enable = 1'b1;
                            flags_reg_enable = 1'b1;
                            operation        = op_q[1:0];
                        end
                        I_MOVE: begin
                            write_reg_enable = 1'b1;
                            c_sel            = 2'd2;
                        end
                        default: begin
                            pc_enable = taken;
                            branch    = taken;
                        end
                    endcase
                end
                default: halt = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_k_and_s_control_unit.sv
// Directed bench for k_and_s_control_unit: expected output vectors go through a
// queue when stimulus is applied and are popped and compared one cycle phase later.

module tb_k_and_s_control_unit;
    import k_and_s_pkg::*;

    localparam int TB_CNT_W = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [4:0]          decoded_instruction;
    logic                zero_op, neg_op, overflow_op, mem_ready;
    logic                mem_req, ram_write_enable, addr_sel, ir_enable, pc_enable, branch;
    logic                write_reg_enable, flags_reg_enable, illegal_instr, halt, bus_error;
    logic [1:0]          c_sel, operation;
    logic [TB_CNT_W-1:0] instr_count;

    logic [14:0]         exp_q[$];
    logic [TB_CNT_W-1:0] exp_count;
    int                  total = 0;
    int                  bad = 0;

    k_and_s_control_unit #(.MEM_TIMEOUT(16), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst(rst), .decoded_instruction(decoded_instruction),
        .zero_op(zero_op), .neg_op(neg_op), .overflow_op(overflow_op),
        .mem_ready(mem_ready), .mem_req(mem_req), .ram_write_enable(ram_write_enable),
        .addr_sel(addr_sel), .ir_enable(ir_enable), .pc_enable(pc_enable),
        .branch(branch), .write_reg_enable(write_reg_enable), .c_sel(c_sel),
        .operation(operation), .flags_reg_enable(flags_reg_enable),
        .illegal_instr(illegal_instr), .halt(halt), .bus_error(bus_error),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    wire [14:0] act = {mem_req, ram_write_enable, addr_sel, ir_enable, pc_enable, branch,
                       write_reg_enable, c_sel, operation, flags_reg_enable,
                       illegal_instr, halt, bus_error};

    function automatic logic [14:0] mk(input logic mr, rwe, as, ir, pc, br, wre,
                                       input logic [1:0] cs, opn,
                                       input logic fre, ill, hlt, be);
        return {mr, rwe, as, ir, pc, br, wre, cs, opn, fre, ill, hlt, be};
    endfunction

    function automatic logic known(input logic [4:0] op);
        return (op <= 5'd14) || (op == 5'd31);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag);
        logic [14:0] e;
        e = exp_q.pop_front();
        total++;
        assert (act === e) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, act, e);
        end
    endtask

    task automatic push_check(input string tag, input logic [14:0] e);
        exp_q.push_back(e);
        #1;
        check_out(tag);
    endtask

    task automatic check_cnt(input string tag);
        total++;
        assert (instr_count === exp_count) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, instr_count, exp_count);
        end
    endtask

    task automatic do_fetch(input int waits);
        for (int i = 0; i < waits; i++) begin
            mem_ready = 1'b0;
            push_check("fetch_wait", mk(1,0,0,0,0,0,0,2'd0,2'd0,0,0,0,0));
            tick();
        end
        mem_ready = 1'b1;
        push_check("fetch_ready", mk(1,0,0,1,1,0,0,2'd0,2'd0,0,0,0,0));
        tick();
        mem_ready = 1'b0;
    endtask

    task automatic do_decode(input logic [4:0] op);
        decoded_instruction = op;
        push_check("decode", mk(0,0,0,0,0,0,0,2'd0,2'd0,0,!known(op),0,0));
        tick();
    endtask

    task automatic run_instr(input logic [4:0] op, input int fw, input int mw,
                             input logic z, input logic n, input logic v);
        logic tk;
        do_fetch(fw);
        do_decode(op);
        if (op == I_LOAD || op == I_STORE) begin
            for (int i = 0; i < mw; i++) begin
                mem_ready = 1'b0;
                push_check("mem_wait", mk(1,op == I_STORE,1,0,0,0,0,2'd0,2'd0,0,0,0,0));
                tick();
            end
            mem_ready = 1'b1;
            if (op == I_LOAD) push_check("load_ready", mk(1,0,1,0,0,0,1,2'd1,2'd0,0,0,0,0));
            else              push_check("store_ready", mk(1,1,1,0,0,0,0,2'd0,2'd0,0,0,0,0));
            tick();
            mem_ready = 1'b0;
            exp_count++;
        end else if (known(op) && op != I_NOP && op != I_HALT) begin
            zero_op = z; neg_op = n; overflow_op = v;
            decoded_instruction = 5'($urandom_range(0, 31));
            case (op)
                I_ADD:  push_check("exec_add",  mk(0,0,0,0,0,0,1,2'd0,2'b00,1,0,0,0));
                I_SUB:  push_check("exec_sub",  mk(0,0,0,0,0,0,1,2'd0,2'b01,1,0,0,0));
                I_AND:  push_check("exec_and",  mk(0,0,0,0,0,0,1,2'd0,2'b10,1,0,0,0));
                I_OR:   push_check("exec_or",   mk(0,0,0,0,0,0,1,2'd0,2'b11,1,0,0,0));
                I_MOVE: push_check("exec_move", mk(0,0,0,0,0,0,1,2'd2,2'b00,0,0,0,0));
                default: begin
                    case (op)
                        I_BRANCH: tk = 1'b1;
                        I_BZERO:  tk = z;
                        I_BNZERO: tk = !z;
                        I_BNEG:   tk = n;
                        I_BNNEG:  tk = !n;
                        I_BOV:    tk = v;
                        default:  tk = !v;
                    endcase
                    push_check("exec_branch", mk(0,0,0,0,tk,tk,0,2'd0,2'd0,0,0,0,0));
                end
            endcase
            tick();
            exp_count++;
        end else if (op == I_NOP || op == I_HALT) begin
            exp_count++;
        end
        check_cnt("instr_count");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] br_ops[7];
        logic z, n, v;
        br_ops = '{I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV};
        rst = 1'b1;
        decoded_instruction = 5'd0;
        {zero_op, neg_op, overflow_op, mem_ready} = 4'b0;
        exp_count = '0;
        tick();
        tick();
        push_check("reset_outputs", '0);
        check_cnt("reset_count");
        rst = 1'b0;

        run_instr(I_ADD, 3, 0, 0, 0, 0);
        run_instr(I_SUB, $urandom_range(0, 3), 0, 1, 0, 0);
        run_instr(I_AND, $urandom_range(0, 3), 0, 0, 1, 0);
        run_instr(I_OR, $urandom_range(0, 3), 0, 0, 0, 1);
        run_instr(I_MOVE, $urandom_range(0, 3), 0, 1, 1, 1);
        run_instr(I_NOP, 0, 0, 0, 0, 0);

        // Counter is 4 bits wide here, so these 14 branches also cross the wrap to zero.
        for (int c = 0; c < 7; c++) begin
            for (int f = 0; f < 2; f++) begin
                z = 1'($urandom_range(0, 1));
                n = 1'($urandom_range(0, 1));
                v = 1'($urandom_range(0, 1));
                if (c == 1 || c == 2) z = 1'(f);
                if (c == 3 || c == 4) n = 1'(f);
                if (c == 5 || c == 6) v = 1'(f);
                run_instr(br_ops[c], $urandom_range(0, 2), 0, z, n, v);
            end
        end

        run_instr(I_LOAD, 15, 15, 0, 0, 0);
        run_instr(I_STORE, 0, 2, 0, 0, 0);
        run_instr(5'b10101, 1, 0, 0, 0, 0);

        do_fetch(1);
        do_decode(I_LOAD);
        mem_ready = 1'b0;
        push_check("mem_before_reset", mk(1,0,1,0,0,0,0,2'd0,2'd0,0,0,0,0));
        rst = 1'b1;
        tick();
        exp_count = '0;
        push_check("reset_mid_mem", '0);
        check_cnt("reset_mid_mem_count");
        rst = 1'b0;
        run_instr(I_ADD, 0, 0, 0, 0, 0);

        do_fetch(0);
        do_decode(I_LOAD);
        for (int i = 0; i < 16; i++) begin
            mem_ready = 1'b0;
            push_check("timeout_wait", mk(1,0,1,0,0,0,0,2'd0,2'd0,0,0,0,0));
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'(i % 2);
            push_check("bus_error_halted", mk(0,0,0,0,0,0,0,2'd0,2'd0,0,0,1,1));
            tick();
        end
        mem_ready = 1'b0;
        check_cnt("timeout_count");

        rst = 1'b1;
        tick();
        exp_count = '0;
        rst = 1'b0;
        run_instr(I_HALT, 2, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'(i % 2);
            decoded_instruction = I_ADD;
            push_check("halt_sticky", mk(0,0,0,0,0,0,0,2'd0,2'd0,0,0,1,0));
            tick();
        end
        check_cnt("halt_count_stable");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
